// File: rtl/wb_sequencer_if.sv
// wb_sequencer_if: bundle of every non-clock, non-reset signal of the
// write-back sequencer.
//   slave  : view taken by wb_sequencer (requests in, write port/flags out)
//   master : view taken by the surrounding core / a testbench
// Ports carried:
//   alu_valid/alu_ready/alu_dest/alu_data : ALU and jal write request handshake
//   ld_issue/ld_dest                      : load issued, destination to queue
//   mem_valid/mem_data                    : in-order returning load data
//   rs/rt                                 : decoder source registers
//   hazard/ld_full/err                    : stall, queue full, sticky error
//   wr_en/wr_addr/wr_data                 : registered register-file write
//   byp_rs_hit/byp_rt_hit/byp_data        : same-cycle load bypass
interface wb_sequencer_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_dest;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hazard;
    logic        ld_full;
    logic        err;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        byp_rs_hit;
    logic        byp_rt_hit;
    logic [31:0] byp_data;

    modport slave (
        input  alu_valid, alu_dest, alu_data, ld_issue, ld_dest,
               mem_valid, mem_data, rs, rt,
        output alu_ready, hazard, ld_full, err, wr_en, wr_addr, wr_data,
               byp_rs_hit, byp_rt_hit, byp_data
    );

    modport master (
        output alu_valid, alu_dest, alu_data, ld_issue, ld_dest,
               mem_valid, mem_data, rs, rt,
        input  alu_ready, hazard, ld_full, err, wr_en, wr_addr, wr_data,
               byp_rs_hit, byp_rt_hit, byp_data
    );
endinterface

// File: rtl/wb_sequencer.sv
// wb_sequencer: single writer for the MIPS register file write port.
// Merges ALU/jal results with in-order returning load data, drives one
// registered write per cycle, keeps a FIFO of outstanding load destinations
// and flags read-after-write hazards on rs/rt.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low; clears queue, write stage and err
//   bus   : wb_sequencer_if.slave (request, load, write-port and flag signals)
// Parameters:
//   LQ_DEPTH : outstanding-load queue entries (power of two, 2..16)
// Build option:
//   WB_BYPASS_EN : when defined, a load popping this cycle is forwarded on
//                  byp_data and clears the hazard for the operand it feeds.
//                  When undefined, byp_* are tied to 0.
module wb_sequencer #(
    parameter int LQ_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    wb_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LQ_DEPTH);

    logic [4:0]       lq_mem [LQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;

    logic             wr_en_p1;
    logic [4:0]       wr_addr_p1;
    logic [31:0]      wr_data_p1;

    logic             q_empty;
    logic             q_full;
    logic             pop;
    logic             push;
    logic             alu_take;
    logic [4:0]       head;

    logic             rs_q;
    logic             rt_q;
    logic             rs_wr;
    logic             rt_wr;
    logic             rs_pend;
    logic             rt_pend;
    logic             byp_rs;
    logic             byp_rt;

    assign q_empty  = (count == '0);
    assign q_full   = (count == FULL_CNT);
    assign head     = lq_mem[rd_ptr];
    // Returning data on an empty queue is not a pop, even with a push this
    // cycle: the new entry waits for its own data.
    assign pop      = bus.mem_valid && !q_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push     = bus.ld_issue && (!q_full || pop);
    assign alu_take = bus.alu_valid && !pop;

    // Destination storage needs no reset: only entries below count are read.
    always_ff @(posedge clock) begin
        if (push) begin
            lq_mem[wr_ptr] <= bus.ld_dest;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if ((bus.ld_issue && q_full && !pop) ||
                (bus.mem_valid && q_empty && !bus.ld_issue)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Stage p1: registered register-file write; loads win over ALU requests.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else if (pop) begin
            wr_en_p1   <= (head != 5'd0);
            wr_addr_p1 <= head;
            wr_data_p1 <= bus.mem_data;
        end else if (alu_take) begin
            wr_en_p1   <= (bus.alu_dest != 5'd0);
            wr_addr_p1 <= bus.alu_dest;
            wr_data_p1 <= bus.alu_data;
        end else begin
            wr_en_p1   <= 1'b0;
        end
    end

    // Match rs/rt against every occupied queue slot, oldest first.
    always_comb begin
        logic [PTR_W-1:0] slot;
        rs_q = 1'b0;
        rt_q = 1'b0;
        slot = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (lq_mem[slot] == bus.rs) rs_q = 1'b1;
                if (lq_mem[slot] == bus.rt) rt_q = 1'b1;
            end
        end
    end

    assign rs_wr   = wr_en_p1 && (wr_addr_p1 == bus.rs);
    assign rt_wr   = wr_en_p1 && (wr_addr_p1 == bus.rt);
    assign rs_pend = (bus.rs != 5'd0) && (rs_q || rs_wr);
    assign rt_pend = (bus.rt != 5'd0) && (rt_q || rt_wr);

`ifdef WB_BYPASS_EN
    logic rs_deep;
    logic rt_deep;

    // A younger entry with the same destination means the head's data is
    // not the value the operand finally needs, so no forwarding then.
    always_comb begin
        logic [PTR_W-1:0] slot;
        rs_deep = 1'b0;
        rt_deep = 1'b0;
        slot    = '0;
        for (int i = 1; i < LQ_DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (lq_mem[slot] == bus.rs) rs_deep = 1'b1;
                if (lq_mem[slot] == bus.rt) rt_deep = 1'b1;
            end
        end
    end

    assign byp_rs       = pop && (bus.rs != 5'd0) && (head == bus.rs) && !rs_deep && !rs_wr;
    assign byp_rt       = pop && (bus.rt != 5'd0) && (head == bus.rt) && !rt_deep && !rt_wr;
    assign bus.byp_data = pop ? bus.mem_data : 32'd0;
`else
    assign byp_rs       = 1'b0;
    assign byp_rt       = 1'b0;
    assign bus.byp_data = 32'd0;
`endif

    assign bus.byp_rs_hit = byp_rs;
    assign bus.byp_rt_hit = byp_rt;
    assign bus.hazard     = (rs_pend && !byp_rs) || (rt_pend && !byp_rt);
    assign bus.alu_ready  = !pop;
    assign bus.ld_full    = q_full;
    assign bus.err        = err_q;
    assign bus.wr_en      = wr_en_p1;
    assign bus.wr_addr    = wr_addr_p1;
    assign bus.wr_data    = wr_data_p1;

endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: table-driven bench for wb_sequencer with a write-port
// scoreboard; hand-written sequences cover bypass, reset and error corners.
module tb_wb_sequencer;
    logic clock;
    logic rst_n;

    wb_sequencer_if bus ();

    wb_sequencer #(.LQ_DEPTH(4)) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        av;
        logic [4:0]  ad;
        logic [31:0] adat;
        logic        li;
        logic [4:0]  ldd;
        logic        mv;
        logic [31:0] md;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        e_rdy;
        logic        e_haz;
        logic        e_full;
        logic        e_err;
        logic        w;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t        tbl[$];
    wr_t         sb[$];
    logic [4:0]  last_a;
    logic [31:0] last_d;
    int          n_vec;
    int          n_err;

    function automatic vec_t V(logic av, logic [4:0] ad, logic [31:0] adat,
                               logic li, logic [4:0] ldd, logic mv, logic [31:0] md,
                               logic [4:0] rs, logic [4:0] rt,
                               logic rdy, logic haz, logic full, logic err,
                               logic w, logic wen, logic [4:0] wa, logic [31:0] wd);
        vec_t v;
        v.av = av; v.ad = ad; v.adat = adat; v.li = li; v.ldd = ldd;
        v.mv = mv; v.md = md; v.rs = rs; v.rt = rt;
        v.e_rdy = rdy; v.e_haz = haz; v.e_full = full; v.e_err = err;
        v.w = w; v.wen = wen; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.en = en; e.a = a; e.d = d;
        sb.push_back(e);
    endtask

    // Write port after the previous edge: either the scoreboard head, or
    // wr_en low with address/data holding the last loaded values.
    task automatic check_wr(input string tag);
        wr_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".wr_en"},   32'(bus.wr_en),   32'(e.en));
            chk({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(e.a));
            chk({tag, ".wr_data"}, bus.wr_data,      e.d);
            last_a = e.a;
            last_d = e.d;
        end else begin
            chk({tag, ".wr_en"},   32'(bus.wr_en),   32'd0);
            chk({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(last_a));
            chk({tag, ".wr_data"}, bus.wr_data,      last_d);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                         input logic li, input logic [4:0] ldd,
                         input logic mv, input logic [31:0] md,
                         input logic [4:0] rs, input logic [4:0] rt);
        bus.alu_valid = av;  bus.alu_dest = ad; bus.alu_data = adat;
        bus.ld_issue  = li;  bus.ld_dest  = ldd;
        bus.mem_valid = mv;  bus.mem_data = md;
        bus.rs        = rs;  bus.rt       = rt;
    endtask

    task automatic step(input string tag);
        @(negedge clock);
        check_wr(tag);
    endtask

    task automatic apply(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        step(t);
        drive(v.av, v.ad, v.adat, v.li, v.ldd, v.mv, v.md, v.rs, v.rt);
        #1;
        chk({t, ".alu_ready"},  32'(bus.alu_ready),  32'(v.e_rdy));
        chk({t, ".hazard"},     32'(bus.hazard),     32'(v.e_haz));
        chk({t, ".ld_full"},    32'(bus.ld_full),    32'(v.e_full));
        chk({t, ".err"},        32'(bus.err),        32'(v.e_err));
        chk({t, ".byp_rs_hit"}, 32'(bus.byp_rs_hit), 32'd0);
        chk({t, ".byp_rt_hit"}, 32'(bus.byp_rt_hit), 32'd0);
        if (v.w) push_wr(v.wen, v.wa, v.wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        last_a = '0;
        last_d = '0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //  av ad  adat          li ldd mv md             rs  rt  rdy haz full err  w wen wa  wd
        tbl.push_back(V(1, 8,  32'h12345678, 0, 0, 0, 32'h0,        8,  0,  1, 0, 0, 0,  1, 1, 8,  32'h12345678));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        8,  0,  1, 1, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        8,  0,  1, 0, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        1, 9, 0, 32'h0,        9,  0,  1, 0, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        9,  0,  1, 1, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 1, 32'hCAFEF00D, 0,  0,  0, 0, 0, 0,  1, 1, 9,  32'hCAFEF00D));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        9,  0,  1, 1, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        9,  0,  1, 0, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        1, 11,0, 32'h0,        0,  0,  1, 0, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(1, 10, 32'h10101010, 0, 0, 1, 32'hA5A5A5A5, 0,  0,  0, 0, 0, 0,  1, 1, 11, 32'hA5A5A5A5));
        tbl.push_back(V(1, 10, 32'h10101010, 0, 0, 0, 32'h0,        11, 10, 1, 1, 0, 0,  1, 1, 10, 32'h10101010));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        10, 0,  1, 1, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        0,  10, 1, 0, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        1, 1, 0, 32'h0,        0,  0,  1, 0, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        1, 2, 0, 32'h0,        1,  0,  1, 1, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        1, 3, 0, 32'h0,        0,  0,  1, 0, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        1, 4, 0, 32'h0,        3,  0,  1, 1, 0, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        1, 5, 0, 32'h0,        5,  4,  1, 1, 1, 0,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        5,  0,  1, 0, 1, 1,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        1, 6, 1, 32'h1001,     0,  0,  0, 0, 1, 1,  1, 1, 1,  32'h1001));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 1, 32'h1002,     0,  0,  0, 0, 1, 1,  1, 1, 2,  32'h1002));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 1, 32'h1003,     0,  0,  0, 0, 0, 1,  1, 1, 3,  32'h1003));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 1, 32'h1004,     0,  0,  0, 0, 0, 1,  1, 1, 4,  32'h1004));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 1, 32'h1006,     0,  0,  0, 0, 0, 1,  1, 1, 6,  32'h1006));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        6,  1,  1, 1, 0, 1,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 1, 32'hDEAD,     0,  0,  1, 0, 0, 1,  0, 0, 0,  32'h0));
        tbl.push_back(V(1, 0,  32'hFFFFFFFF, 0, 0, 0, 32'h0,        0,  0,  1, 0, 0, 1,  1, 0, 0,  32'hFFFFFFFF));
        tbl.push_back(V(1, 31, 32'h00400008, 0, 0, 0, 32'h0,        0,  0,  1, 0, 0, 1,  1, 1, 31, 32'h00400008));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        31, 0,  1, 1, 0, 1,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        0,  0,  1, 0, 0, 1,  0, 0, 0,  32'h0));
        tbl.push_back(V(1, 12, 32'h1,        0, 0, 0, 32'h0,        31, 0,  1, 0, 0, 1,  1, 1, 12, 32'h1));
        tbl.push_back(V(1, 13, 32'h2,        0, 0, 0, 32'h0,        12, 0,  1, 1, 0, 1,  1, 1, 13, 32'h2));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        13, 12, 1, 1, 0, 1,  0, 0, 0,  32'h0));
        tbl.push_back(V(0, 0,  32'h0,        0, 0, 0, 32'h0,        13, 0,  1, 0, 0, 1,  0, 0, 0,  32'h0));

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst.alu_ready",  32'(bus.alu_ready),  32'd1);
        chk("rst.hazard",     32'(bus.hazard),     32'd0);
        chk("rst.ld_full",    32'(bus.ld_full),    32'd0);
        chk("rst.err",        32'(bus.err),        32'd0);
        chk("rst.wr_en",      32'(bus.wr_en),      32'd0);
        chk("rst.wr_addr",    32'(bus.wr_addr),    32'd0);
        chk("rst.wr_data",    bus.wr_data,         32'd0);
        chk("rst.byp_rs_hit", 32'(bus.byp_rs_hit), 32'd0);
        chk("rst.byp_rt_hit", 32'(bus.byp_rt_hit), 32'd0);
        chk("rst.byp_data",   bus.byp_data,        32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Bypass: single pending load to 5 returns while rt = 5
        step("byp0"); drive(0, 0, 0, 1, 5, 0, 0, 0, 0);
        step("byp1"); drive(0, 0, 0, 0, 0, 0, 0, 0, 5);
        #1 chk("byp1.hazard", 32'(bus.hazard), 32'd1);
        step("byp2"); drive(0, 0, 0, 0, 0, 1, 32'h77, 0, 5);
        #1;
        chk("byp2.alu_ready",  32'(bus.alu_ready),  32'd0);
        chk("byp2.byp_rs_hit", 32'(bus.byp_rs_hit), 32'd0);
`ifdef WB_BYPASS_EN
        chk("byp2.byp_rt_hit", 32'(bus.byp_rt_hit), 32'd1);
        chk("byp2.byp_data",   bus.byp_data,        32'h77);
        chk("byp2.hazard",     32'(bus.hazard),     32'd0);
`else
        chk("byp2.byp_rt_hit", 32'(bus.byp_rt_hit), 32'd0);
        chk("byp2.byp_data",   bus.byp_data,        32'd0);
        chk("byp2.hazard",     32'(bus.hazard),     32'd1);
`endif
        push_wr(1, 5, 32'h77);

        // Two loads to 5: head forwarding blocked by the younger entry,
        // then by the pending write of the first one.
        step("dup0"); drive(0, 0, 0, 1, 5, 0, 0, 0, 0);
        step("dup1"); drive(0, 0, 0, 1, 5, 0, 0, 0, 0);
        step("dup2"); drive(0, 0, 0, 0, 0, 1, 32'h55, 0, 5);
        #1;
        chk("dup2.byp_rt_hit", 32'(bus.byp_rt_hit), 32'd0);
        chk("dup2.hazard",     32'(bus.hazard),     32'd1);
        push_wr(1, 5, 32'h55);
        step("dup3"); drive(0, 0, 0, 0, 0, 1, 32'h56, 0, 5);
        #1;
        chk("dup3.byp_rt_hit", 32'(bus.byp_rt_hit), 32'd0);
        chk("dup3.hazard",     32'(bus.hazard),     32'd1);
        push_wr(1, 5, 32'h56);
        step("dup4"); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-operation: two queued loads and a write in the stage
        step("mr0"); drive(0, 0, 0, 1, 14, 0, 0, 0, 0);
        step("mr1"); drive(0, 0, 0, 1, 15, 0, 0, 0, 0);
        step("mr2"); drive(1, 20, 32'hABCD, 0, 0, 0, 0, 0, 0);
        push_wr(1, 20, 32'hABCD);
        step("mr3"); drive(0, 0, 0, 0, 0, 0, 0, 14, 0);
        rst_n = 1'b0;
        #1;
        chk("mr3.wr_en",     32'(bus.wr_en),     32'd0);
        chk("mr3.wr_addr",   32'(bus.wr_addr),   32'd0);
        chk("mr3.wr_data",   bus.wr_data,        32'd0);
        chk("mr3.err",       32'(bus.err),       32'd0);
        chk("mr3.ld_full",   32'(bus.ld_full),   32'd0);
        chk("mr3.alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("mr3.hazard",    32'(bus.hazard),    32'd0);
        sb.delete();
        last_a = '0;
        last_d = '0;
        @(negedge clock);
        rst_n = 1'b1;

        // Push and mem_valid together on an empty queue: no pop, no error
        step("pe0"); drive(0, 0, 0, 1, 17, 1, 32'hBAD, 0, 0);
        #1 chk("pe0.alu_ready", 32'(bus.alu_ready), 32'd1);
        step("pe1"); drive(0, 0, 0, 0, 0, 0, 0, 17, 0);
        #1;
        chk("pe1.hazard", 32'(bus.hazard), 32'd1);
        chk("pe1.err",    32'(bus.err),    32'd0);
        step("pe2"); drive(0, 0, 0, 0, 0, 1, 32'h17, 0, 0);
        #1 chk("pe2.alu_ready", 32'(bus.alu_ready), 32'd0);
        push_wr(1, 17, 32'h17);
        // mem_valid on an empty queue without a push: ignored, err sets
        step("pe3"); drive(0, 0, 0, 0, 0, 1, 32'h99, 0, 0);
        #1;
        chk("pe3.alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("pe3.err",       32'(bus.err),       32'd0);
        step("pe4"); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("pe4.err", 32'(bus.err), 32'd1);
        step("pe5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
